// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern engine: walking modes and bounce direction.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_R  = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } led_mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Pin-side bundle of the LED pattern engine: buttons in, LED bank and status out.
interface led_pattern_engine_if #(
  parameter int unsigned WIDTH = 8
) ();
  import led_pattern_pkg::*;

  logic [WIDTH-1:0] Switch;
  logic             Mode_btn;
  logic [WIDTH-1:0] LED;
  led_mode_t        Mode;
  logic             Tick;

  modport master (output Switch, Mode_btn, input LED, Mode, Tick);
  modport slave  (input Switch, Mode_btn, output LED, Mode, Tick);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus stability debouncer for a vector of active-low buttons.
// LED_PATTERN_DEBOUNCE_EN undefined: the synchroniser output is passed straight through.
module input_debouncer #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Released state is all ones, so reset to that.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_PATTERN_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt;

  // Any change of the synchronised vector restarts the stability count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand <= '1;
      r_deb  <= '1;
      r_cnt  <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
      r_deb  <= r_cand;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_dout = r_deb;
`else
  if (DEB_CYCLES == 0) begin : g_deb_cycles_unused
  end

  assign o_dout = r_sync2;
`endif

endmodule

// File: rtl/led_pattern_engine.sv
// Push-button LED pattern controller: button load or prescaled walk in four modes.
// Input debouncing is enabled by defining LED_PATTERN_DEBOUNCE_EN.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TICK_DIV   = 16777216,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  led_pattern_engine_if.slave  bus
);

  localparam int unsigned TCW = $clog2(TICK_DIV);

  logic [TCW-1:0]   r_pre_cnt;
  logic [TCW-1:0]   w_pre_nxt;
  logic             r_tick;
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] w_led_nxt;
  logic [WIDTH-1:0] w_sw_deb;
  logic [WIDTH-1:0] w_load;
  logic             w_md_deb;
  logic             r_md_prev;
  logic             w_mode_edge;
  logic             r_dir;
  logic             w_dir_nxt;
  led_mode_t        r_mode;
  led_mode_t        w_mode_nxt;

  input_debouncer #(.WIDTH(WIDTH), .DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .i_din  (bus.Switch),
    .o_dout (w_sw_deb)
  );

  input_debouncer #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_md_deb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .i_din  (bus.Mode_btn),
    .o_dout (w_md_deb)
  );

  assign w_pre_nxt   = (r_pre_cnt == TCW'(TICK_DIV - 1)) ? '0 : r_pre_cnt + TCW'(1);
  assign w_mode_edge = r_md_prev & ~w_md_deb;

  // One-hot of the lowest-index pressed switch; scanning downward lets low bits win.
  always_comb begin
    w_load = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!w_sw_deb[i]) w_load = WIDTH'(1) << i;
    end
  end

  always_comb begin
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir;
    w_mode_nxt = r_mode;
    if (w_mode_edge) w_mode_nxt = led_mode_t'(r_mode + 2'd1);
    if (r_tick) begin
      if (~&w_sw_deb) begin
        w_led_nxt = w_load;
      end else begin
        case (r_mode)
          MODE_ROT_R: w_led_nxt = {r_led[0], r_led[WIDTH-1:1]};
          MODE_ROT_L: w_led_nxt = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
          MODE_BOUNCE: begin
            // Reversal at either end steps back inward instead of wrapping.
            if (r_dir == DIR_UP) begin
              if (r_led[WIDTH-1]) begin
                w_dir_nxt = DIR_DOWN;
                w_led_nxt = r_led >> 1;
              end else begin
                w_led_nxt = r_led << 1;
              end
            end else begin
              if (r_led[0]) begin
                w_dir_nxt = DIR_UP;
                w_led_nxt = r_led << 1;
              end else begin
                w_led_nxt = r_led >> 1;
              end
            end
          end
          MODE_HOLD: w_led_nxt = r_led;
          default:   w_led_nxt = r_led;
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_pre_cnt <= '0;
      r_tick    <= 1'b0;
      r_led     <= WIDTH'(1);
      r_dir     <= DIR_UP;
      r_mode    <= MODE_ROT_R;
      r_md_prev <= 1'b1;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_tick    <= (w_pre_nxt == TCW'(TICK_DIV - 1));
      r_led     <= w_led_nxt;
      r_dir     <= w_dir_nxt;
      r_mode    <= w_mode_nxt;
      r_md_prev <= w_md_deb;
    end
  end

  assign bus.LED  = r_led;
  assign bus.Mode = r_mode;
  assign bus.Tick = r_tick;

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised push-button LED pattern controller for the LED expansion module demos. It drives a WIDTH-bit LED bank from WIDTH active-low push buttons and one active-low mode button. A pressed button loads a one-hot position. Otherwise the lit bit walks in one of four modes at a prescaled step rate. Everything runs on the board clock with a one-cycle step enable, with no derived clocks; it sits directly between the expansion header pins and the top level.

## Interface
- `WIDTH`, 8: number of LEDs and switches; legal range is 2 or more.
- `TICK_DIV`, 16777216: board clocks per pattern step (about 6 Hz at 100 MHz); legal range is 2 or more.
- `DEB_CYCLES`, 1000000: number of clocks an input must stay stable before it is accepted (10 ms at 100 MHz).
- `Clk` in 1: board clock; the whole block is in this domain.
- `Rst_n` in 1: reset, synchronous, active-low.
- `Switch` in WIDTH: push buttons, active-low, asynchronous to `Clk`.
- `Mode_btn` in 1: mode-advance button, active-low, asynchronous.
- `LED` out WIDTH: LED drive, active-high, registered.
- `Mode` out 2: current mode, registered.
- `Tick` out 1: one-cycle step strobe, registered.

## Operation
- Reset (when `Rst_n`=0 at a rising `Clk` edge):
  - `LED`=1 (bit 0 lit), `Mode`=0, `Tick`=0.
  - Prescaler and debounce counters = 0.
  - Bounce direction = up (toward the MSB).
  - Debounced inputs = all released (1).
- Prescaler: counts 0 to TICK_DIV-1, then wraps to 0. `Tick`=1 for exactly the one cycle in which count = TICK_DIV-1.
- Input conditioning:
  - Each input passes through a 2-flop synchroniser, then a debouncer.
  - The debounced value takes the synchronised value once that value has been unchanged for DEB_CYCLES consecutive clocks.
  - Any change in the synchronised value restarts the count.
  - `Switch` uses one vector-wide debouncer; `Mode_btn` uses its own debouncer.
- Modes (values live in the package):
  - ROT_R=0: `LED` <= {LED[0], LED[WIDTH-1:1]}.
  - ROT_L=1: `LED` <= {LED[WIDTH-2:0], LED[WIDTH-1]}.
  - BOUNCE=2: shift one position in the current direction. If direction is up and LED[WIDTH-1]=1, the direction flips to down and the step moves the bit to WIDTH-2. The mirror rule applies at LED[0]. Reversal never wraps.
  - HOLD=3: `LED` unchanged.
- Step on a tick edge:
  - If any debounced switch is low, `LED` <= one-hot of the lowest-index pressed switch. The lowest index has priority. Direction is unchanged.
  - Otherwise `LED` <= the mode step above.
  - Between ticks, `LED` holds.
- Mode advance: on a debounced high-to-low edge of `Mode_btn`, `Mode` <= `Mode`+1, wrapping 3 to 0. This is independent of `Tick`.
- Simultaneous events: if a mode edge and a tick fall on the same edge, the LED step uses the old mode and the new mode applies from the next tick.
- Held buttons: a switch held across several ticks reloads the same one-hot value on every tick, so the LED freezes. On release, walking resumes from that position at the following tick.

## Timing
- Input to debounced value: 2 sync cycles plus DEB_CYCLES clocks.
- `LED` and `Mode` change on the rising edge where `Tick`=1 or a mode edge is detected, and are visible the cycle after.
- The first `Tick` after reset release comes TICK_DIV cycles later.
- Reset wins over every event on the same edge.
- No combinational path from any input to any output.

## Configuration
- `LED_PATTERN_DEBOUNCE_EN` defined: the debouncers are instantiated as described above.
- Not defined: debouncers are bypassed. The debounced value equals the synchroniser output, latency is 2 cycles, and `DEB_CYCLES` is ignored. This mode is for simulation and for boards with hardware-debounced buttons.

## Structure
- Package `led_pattern_pkg`:
  - `led_mode_t` 2-bit enum: MODE_ROT_R, MODE_ROT_L, MODE_BOUNCE, MODE_HOLD.
  - Direction constants DIR_UP and DIR_DOWN.
- Sub-module `input_debouncer`:
  - Parameters: WIDTH and DEB_CYCLES.
  - Contains the synchroniser and the `LED_PATTERN_DEBOUNCE_EN` bypass.
  - Instantiated twice: WIDTH=`WIDTH` for `Switch` and WIDTH=1 for `Mode_btn`.

## Test plan
Bench parameters: WIDTH=8, TICK_DIV=4, DEB_CYCLES=3, macro defined unless stated.
- Reset, then 3 ticks with no buttons pressed: `LED` goes 0x01 to 0x80, 0x40, 0x20; `Tick` period is 4 cycles.
- Press `Switch`[5] and `Switch`[2] together (held low), wait past debounce plus one tick: `LED`=0x04. Release, then 1 tick: `LED`=0x02.
- Pulse `Mode_btn` twice (BOUNCE), load 0x40, then 3 ticks: `LED`=0x80, 0x40, 0x20, i.e. it reverses without wrapping.
- Toggle `Switch`[3] every 2 cycles for 20 cycles (glitch): `LED` is never loaded with 0x08. Repeat with the macro undefined: the load occurs.
- Assert `Rst_n`=0 during a tick cycle in BOUNCE mode: the next cycle shows `LED`=0x01, `Mode`=0, `Tick`=0, and the first new tick arrives 4 cycles after release.
- Mode edge on the same clock as a tick in ROT_R from 0x10: `LED`=0x08 and `Mode`=1; the next tick gives `LED`=0x10.
